// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with one-entry output slot
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  valid_f,
    output logic [DATA_WIDTH-1:0] read_data_f,
    output logic [DATA_WIDTH-1:0] PC_f,
    output logic [DATA_WIDTH-1:0] PCPlus4_f
);

    typedef enum logic {S_REQ, S_WAIT} state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   pc, req_pc, hold_data, hold_pc;
    logic                    drop, hold_valid;
    logic                    req_fire, consume, resp_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_REQ;
        else        state <= state_next;
    end

    // A response always returns us to S_REQ, whether it is kept, dropped or
    // collides with a redirect; req_fire already excludes redirect cycles.
    always_comb begin
        state_next = state;
        case (state)
            S_REQ:   if (req_fire)    state_next = S_WAIT;
            S_WAIT:  if (imem_rvalid) state_next = S_REQ;
            default: state_next = S_REQ;
        endcase
    end

    always_comb begin
        imem_req  = rst_n && (state == S_REQ) && !redirect && (!hold_valid || en);
        imem_addr = pc;
        req_fire  = imem_req && imem_ready;
        consume   = hold_valid && en && !redirect;
        resp_take = (state == S_WAIT) && imem_rvalid && !drop && !redirect;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            req_pc     <= '0;
            drop       <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_pc    <= '0;
        end else begin
            if (redirect)      pc <= redirect_pc;
            else if (req_fire) pc <= pc + DATA_WIDTH'(4);

            if (req_fire) req_pc <= pc;

            // drop marks an in-flight response that belongs to a flushed path
            if (state == S_WAIT) begin
                if (imem_rvalid)   drop <= 1'b0;
                else if (redirect) drop <= 1'b1;
            end

            if (resp_take)                hold_valid <= 1'b1;
            else if (consume || redirect) hold_valid <= 1'b0;

            if (resp_take) begin
                hold_data <= imem_rdata;
                hold_pc   <= req_pc;
            end
        end
    end

    assign valid_f     = hold_valid;
    assign read_data_f = hold_data;
    assign PC_f        = hold_pc;
    assign PCPlus4_f   = hold_pc + DATA_WIDTH'(4);

    assert property (@(posedge clk) disable iff (!rst_n) (state == S_WAIT) |-> !hold_valid);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end for the pipelined core. It owns the program counter and issues one request at a time to the instruction memory/cache. It holds each returned instruction in a one-entry output slot and presents it to the fetch/decode pipeline register as valid_f / read_data_f / PC_f / PCPlus4_f. It honours the decode-side stall (en) and discards in-flight fetches on a branch/jump redirect from execute.

## Interface
Parameters:
- DATA_WIDTH, 32, width of addresses, PC and instruction words
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  downstream accepts; low = decode stalled
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  DATA_WIDTH  new fetch address, valid when redirect=1
- imem_req  out  1  fetch request valid
- imem_addr  out  DATA_WIDTH  fetch address
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid (in order, ≥1 cycle after acceptance)
- imem_rdata  in  DATA_WIDTH  instruction word
- valid_f  out  1  output slot holds a valid instruction
- read_data_f  out  DATA_WIDTH  instruction word
- PC_f  out  DATA_WIDTH  address of that instruction
- PCPlus4_f  out  DATA_WIDTH  PC_f + 4

## Operation
- State: pc (next fetch address), req_pc, FSM {S_REQ, S_WAIT}, drop flag, hold slot (hold_valid, hold_data, hold_pc).
- Outputs: valid_f=hold_valid, read_data_f=hold_data, PC_f=hold_pc, PCPlus4_f=hold_pc+4 (mod 2^DATA_WIDTH). With valid_f=0, the data outputs keep their last values.
- Slot consumption: a transfer occurs on an edge with valid_f=1, en=1, redirect=0. hold_valid clears on that edge.
- S_REQ:
  - imem_req = !redirect && (!hold_valid || en). imem_addr = pc.
  - The request may drop or change between cycles. Only a cycle with imem_req && imem_ready is a transfer.
  - On transfer: req_pc<=pc, pc<=pc+4 (wraps), go to S_WAIT.
  - Any imem_rvalid seen in S_REQ is ignored.
- S_WAIT:
  - imem_req=0. hold_valid is always 0 here (invariant; assert it).
  - On imem_rvalid with drop=0: hold_valid<=1, hold_data<=imem_rdata, hold_pc<=req_pc, go to S_REQ.
  - On imem_rvalid with drop=1: discard the response, drop<=0, go to S_REQ.
- Redirect has highest priority. On an edge with redirect=1:
  - pc<=redirect_pc, hold_valid<=0, and no request is accepted that cycle.
  - In S_WAIT without imem_rvalid: drop<=1, stay in S_WAIT.
  - In S_WAIT with imem_rvalid: discard the response, go to S_REQ.
  - In S_REQ: stay.
  - A redirect while drop=1 only updates pc.
- redirect_pc is used unmodified; misalignment is not checked.
- Only one request is outstanding at any time.

## Timing
- Reset (async assert): pc=RESET_PC, req_pc=0, FSM=S_REQ, drop=0, hold_valid=0, hold_data=0, hold_pc=0.
  - Outputs after reset: valid_f=0, read_data_f=0, PC_f=0, PCPlus4_f=4.
  - The first imem_req is asserted in the first cycle after rst_n deasserts.
  - A reset mid-fetch abandons the outstanding request.
- Latency, memory with ready=1 and 1-cycle response: request accepted in cycle N, rvalid in N+1, valid_f high in N+2.
- Throughput with en=1: one instruction per 2 cycles. The next request is issued in the same cycle the slot is consumed.
- en=0 with valid_f=1: the slot and all outputs are held stable and imem_req=0. Fetch resumes in the cycle en returns high.
- Redirect in cycle N: valid_f=0 from N+1. The first request to redirect_pc is issued in N+1, or one cycle after the stale response returns when a drop is pending.

## Test plan
- Reset: hold rst_n=0 → valid_f=0, PC_f=0, PCPlus4_f=4, imem_req=0 during reset. Release → imem_req=1, imem_addr=RESET_PC=0.
- Stream, 1-cycle memory, en=1, rdata=addr^32'hA5A5_0000 → valid_f pulses every 2nd cycle with PC_f=0,4,8,12, PCPlus4_f=4,8,12,16 and matching data.
- Stall: en=0 for 5 cycles while valid_f=1 (PC_f=8) → outputs frozen, imem_req=0. en=1 → PC_f=8 is consumed, then the next request is to 12.
- Backpressure: imem_ready=0 for 4 cycles → imem_req=1, imem_addr=4 held, pc unchanged. Acceptance when ready rises.
- Redirect in S_WAIT: 3-cycle memory, redirect=1 with redirect_pc=0x100 one cycle after acceptance of 0x20 → the 0x20 response is dropped (valid_f never shows PC 0x20), and the next valid_f has PC_f=0x100.
- Wrap: redirect_pc=32'hFFFF_FFFC → PC_f=FFFF_FFFC, PCPlus4_f=0, and the next imem_addr=0.
